burst_ram_responder: RTL and testbench
======================================

// Module: burst_ram_responder
// PURPOSE
//  Responder end of the burst RAM command interface driven by the cache.
//  Models the PSRAM IP: accepts read/write commands and services 4 x 64-bit bursts.
//  Includes init/calibration delay, read latency and minimum command interval.
//  Used in simulation and in FPGA builds without PSRAM, placed directly behind the cache.
// PARAMETERS
//  DEPTH_BITWIDTH           21  address width, unit = 8-byte word
//  BURST_COUNT               4  64-bit words per command (fixed at 4, checked at elaboration)
//  CYCLES_BEFORE_INITIATED  10  cycles after reset release before init_calib rises
//  CYCLES_BEFORE_DATA_VALID  6  cycles from accepted read cmd_en to first rd_data_valid
//  COMMAND_DELAY_INTERVAL   14  minimum cycles between accepted commands
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  cmd            in   1   0: read, 1: write; sampled with cmd_en
//  cmd_en         in   1   command and addr valid this cycle
//  addr           in   DEPTH_BITWIDTH  first 8-byte word of burst
//  wr_data        in   64  write data; word 0 with cmd_en, words 1..3 on the next 3 cycles
//  data_mask      in   8   accepted, ignored (all bytes always written)
//  rd_data        out  64  read data
//  rd_data_valid  out  1   rd_data valid this cycle
//  init_calib     out  1   1: ready to accept commands
//  busy           out  1   1: a command issued now would be rejected
//  cmd_error      out  1   sticky: cmd_en seen while busy or before init_calib
// BEHAVIOUR
//  Reset values: rd_data=0, rd_data_valid=0, init_calib=0, busy=1, cmd_error=0, state=INIT.
//  Reset does not clear memory contents.
//  INIT: counts CYCLES_BEFORE_INITIATED cycles, then init_calib<=1 (stays 1 until reset) -> IDLE.
//  busy = !init_calib || state!=IDLE || interval_counter!=0.
//  Accept: cmd_en && !busy. The interval counter loads COMMAND_DELAY_INTERVAL-1 on accept,
//   decrements to 0, and runs independently of the burst state.
//  Reject: cmd_en && busy sets cmd_error<=1. No other effect. Only rst clears cmd_error.
//  Write (cmd=1): in the accept cycle, mem[addr] <= wr_data.
//   WRITE_1..WRITE_3 then write mem[addr+i] <= wr_data on the following 3 cycles.
//   Then -> IDLE. cmd_en/cmd/addr are ignored during WRITE_n; cmd_en there sets cmd_error.
//  Read (cmd=1'b0): latch addr and enter READ_WAIT.
//   First valid word appears exactly CYCLES_BEFORE_DATA_VALID cycles after the accept edge.
//   Then READ_DATA holds rd_data_valid=1 for 4 consecutive cycles: mem[addr+0..3], in order.
//   Then rd_data_valid<=0 -> IDLE. rd_data holds its last value when not valid.
//  Address arithmetic: addr+i is modulo 2^DEPTH_BITWIDTH (wraps at top). No alignment required.
//  Read-after-write: a read accepted after a write returns the newly written data.
//   The interval guarantees the write has completed.
//  rst mid-burst: next edge forces rd_data_valid=0 and state=INIT; partial writes already done stay.
//  Memory read is registered (1-cycle): latency counter accounts for it so the valid timing is exact.
// STRUCTURE
//  Package burst_ram_pkg: state enum {INIT, IDLE, WRITE_1, WRITE_2, WRITE_3, READ_WAIT, READ_DATA},
//   BURST_COUNT constant, CMD_READ/CMD_WRITE constants.
//  Sub-module burst_ram_array: single-port 64-bit x 2^DEPTH_BITWIDTH.
//   Sync write, registered read, optional $readmemh init file parameter.
//  Top: FSM, latency/burst/interval/init counters, error flag.
// TESTING
//  Init: release rst -> init_calib=0 for 10 cycles, 1 at cycle 10; cmd_en at cycle 5 -> cmd_error=1.
//  Write/read: write addr 0x10, data 0x1111..,0x2222..,0x3333..,0x4444..; wait 14;
//   read 0x10 -> 4 valid beats in order, first exactly 6 cycles after cmd_en.
//  Interval: second cmd_en 13 cycles after an accepted cmd -> rejected, cmd_error=1;
//   at 14 cycles -> accepted.
//  Wrap: write burst at addr 0x1FFFFE -> words land at 0x1FFFFE, 0x1FFFFF, 0x0, 0x1; read back matches.
//  Reset mid-read: assert rst during beat 2 -> rd_data_valid=0 next cycle;
//   after re-init, read returns previously written data unchanged.
//  Cache integration: Cache (LINE_IX_BITWIDTH=8) miss/evict/refill traffic;
//   a scoreboard compares every data_out with a reference memory and cmd_error stays 0.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the burst RAM responder.
package burst_ram_pkg;

    localparam int   BURST_COUNT = 4;
    localparam logic CMD_READ    = 1'b0;
    localparam logic CMD_WRITE   = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE_1,
        WRITE_2,
        WRITE_3,
        READ_WAIT,
        READ_DATA
    } state_e;

endpackage

// File: rtl/burst_ram_array.sv
// Single-port word memory: synchronous write, registered read (old data on same-address write).
module burst_ram_array #(
    parameter int AW = 21,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram_responder.sv
// PSRAM-like responder: init delay, 4-word write/read bursts, fixed read latency,
// minimum command interval and a sticky error for commands issued while busy.
module burst_ram_responder #(
    parameter int DEPTH_BITWIDTH           = 21,
    parameter int BURST_COUNT              = burst_ram_pkg::BURST_COUNT,
    parameter int CYCLES_BEFORE_INITIATED  = 10,
    parameter int CYCLES_BEFORE_DATA_VALID = 6,
    parameter int COMMAND_DELAY_INTERVAL   = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [63:0]               wr_data,
    input  logic [7:0]                data_mask,
    output logic [63:0]               rd_data,
    output logic                      rd_data_valid,
    output logic                      init_calib,
    output logic                      busy,
    output logic                      cmd_error
);
    import burst_ram_pkg::*;

    localparam int AW = DEPTH_BITWIDTH;
    localparam int NW = $clog2(CYCLES_BEFORE_INITIATED + 1);
    localparam int IW = $clog2(COMMAND_DELAY_INTERVAL + 1);
    localparam int LW = $clog2(CYCLES_BEFORE_DATA_VALID + 1);
    localparam int BW = $clog2(BURST_COUNT + 2);

    if (BURST_COUNT != 4) begin : g_bad_burst
        $error("burst_ram_responder: BURST_COUNT must be 4");
    end
    if (CYCLES_BEFORE_DATA_VALID < 3) begin : g_bad_latency
        $error("burst_ram_responder: CYCLES_BEFORE_DATA_VALID must be >= 3");
    end

    state_e          state_q, state_d;
    logic [NW-1:0]   init_cnt_q, init_cnt_d;
    logic [IW-1:0]   ivl_q, ivl_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   base_q, base_d;
    logic            init_calib_q, init_calib_d;
    logic            cmd_error_q, cmd_error_d;
    logic            issue_q, issue_d;
    logic            rd_valid_q;
    logic [63:0]     rd_data_q;
    logic            busy_c, accept;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [63:0]     ram_rdata;
    logic            unused_mask;

    assign unused_mask = ^data_mask;

    assign busy_c = !init_calib_q || (state_q != IDLE) || (ivl_q != '0);
    assign accept = cmd_en && !busy_c;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        ivl_d        = ivl_q;
        lat_d        = lat_q;
        beat_d       = beat_q;
        base_d       = base_q;
        init_calib_d = init_calib_q;
        cmd_error_d  = cmd_error_q;
        issue_d      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = base_q + AW'(beat_q);

        if (cmd_en && busy_c) cmd_error_d = 1'b1;
        if (ivl_q != '0)      ivl_d = ivl_q - 1'b1;
        if (accept)           ivl_d = IW'(COMMAND_DELAY_INTERVAL - 1);

        case (state_q)
            INIT: begin
                if (init_cnt_q == NW'(CYCLES_BEFORE_INITIATED - 1)) begin
                    init_calib_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    base_d = addr;
                    if (cmd == CMD_WRITE) begin
                        ram_we   = 1'b1;
                        ram_addr = addr;
                        state_d  = WRITE_1;
                    end else begin
                        // Two cycles of the latency are spent in the RAM and output registers.
                        lat_d   = LW'(CYCLES_BEFORE_DATA_VALID - 3);
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE_1: begin
                ram_we = 1'b1; ram_addr = base_q + AW'(1); state_d = WRITE_2;
            end
            WRITE_2: begin
                ram_we = 1'b1; ram_addr = base_q + AW'(2); state_d = WRITE_3;
            end
            WRITE_3: begin
                ram_we = 1'b1; ram_addr = base_q + AW'(3); state_d = IDLE;
            end
            READ_WAIT: begin
                if (lat_q == '0) begin
                    beat_d  = '0;
                    state_d = READ_DATA;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            READ_DATA: begin
                // Stay until the last beat has drained through the output register.
                issue_d = (beat_q < BW'(BURST_COUNT));
                beat_d  = beat_q + 1'b1;
                if (beat_q == BW'(BURST_COUNT + 1)) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            ivl_q        <= '0;
            lat_q        <= '0;
            beat_q       <= '0;
            init_calib_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            issue_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ivl_q        <= ivl_d;
            lat_q        <= lat_d;
            beat_q       <= beat_d;
            init_calib_q <= init_calib_d;
            cmd_error_q  <= cmd_error_d;
            issue_q      <= issue_d;
            rd_valid_q   <= issue_q;
            if (issue_q) rd_data_q <= ram_rdata;
        end
    end

    always_ff @(posedge clk) base_q <= base_d;

    burst_ram_array #(.AW(AW), .DW(64)) u_array (
        .clk     (clk),
        .we_i    (ram_we && !rst),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign init_calib    = init_calib_q;
    assign busy          = busy_c;
    assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Randomized scoreboard bench for burst_ram_responder against a word-addressed reference memory.
module tb_burst_ram_responder;

    localparam logic [20:0] AMASK = 21'h1FFFFF;

    logic        clk, rst, cmd, cmd_en;
    logic [20:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid, init_calib, busy, cmd_error;

    burst_ram_responder dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
        .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .init_calib(init_calib),
        .busy(busy), .cmd_error(cmd_error)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_mem [int unsigned];
    int unsigned bases[$];
    int          cyc = 0;
    int          next_ok = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Scoreboard monitor: every valid beat must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_beat: no valid beat, expected %h at cycle %0d", exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got data %h at cycle %0d, expected no beat", rd_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_data", rd_data, e.data);
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_reset(input logic probe);
        rst = 1'b1;
        cmd_en = 1'b0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_valid", 64'(rd_data_valid), 64'h0);
        chk("rst_init_calib", 64'(init_calib), 64'h0);
        chk("rst_busy", 64'(busy), 64'h1);
        chk("rst_cmd_error", 64'(cmd_error), 64'h0);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk("init_calib_timing", 64'(init_calib), 64'(i == 10));
            if (probe) begin
                cmd_en = (i == 4);
                cmd = 1'b0;
                addr = 21'h10;
            end
            tick();
        end
        cmd_en = 1'b0;
        chk("init_cmd_error", 64'(cmd_error), 64'(probe));
        next_ok = cyc;
    endtask

    task automatic do_write(input logic [20:0] a, input logic [3:0][63:0] d);
        wait_until(next_ok);
        chk("busy_before_write", 64'(busy), 64'h0);
        next_ok = cyc + 14;
        cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = d[0];
        tick();
        cmd_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wr_data = d[i];
            tick();
        end
        for (int i = 0; i < 4; i++) ref_mem[int'((a + 21'(i)) & AMASK)] = d[i];
        bases.push_back(int'(a));
    endtask

    task automatic do_read(input logic [20:0] a, input int nexp);
        int c;
        wait_until(next_ok);
        chk("busy_before_read", 64'(busy), 64'h0);
        c = cyc;
        next_ok = c + 14;
        for (int i = 0; i < nexp; i++) begin
            logic [20:0] wa;
            exp_t e;
            wa = a + 21'(i);
            e.data = ref_mem.exists(int'(wa)) ? ref_mem[int'(wa)] : 64'h0;
            e.cyc = c + 7 + i;
            exp_q.push_back(e);
        end
        cmd_en = 1'b1; cmd = 1'b0; addr = a;
        tick();
        cmd_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion by 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][63:0] d;
        int c;
        rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;

        // Early command during init is flagged; a clean reset clears the flag.
        do_reset(1'b1);
        do_reset(1'b0);

        d = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        do_write(21'h10, d);
        do_read(21'h10, 4);

        // Pre-fill 0..3 so the wrap write visibly overwrites only 0 and 1.
        d = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
        do_write(21'h0, d);
        d = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
        do_write(21'h1FFFFE, d);
        do_read(21'h1FFFFE, 4);
        do_read(21'h0, 4);

        for (int n = 0; n < 40; n++) begin
            next_ok = next_ok + int'($urandom_range(0, 3));
            if (bases.size() == 0 || $urandom_range(0, 1) == 1) begin
                logic [20:0] a;
                a = ($urandom_range(0, 3) == 0) ? 21'h1FFFFC + 21'($urandom_range(0, 3))
                                                : 21'($urandom);
                for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
                do_write(a, d);
            end else begin
                do_read(21'(bases[$urandom_range(0, bases.size() - 1)]), 4);
            end
        end
        chk("no_error_after_traffic", 64'(cmd_error), 64'h0);

        // Command 13 cycles after an accept is rejected; 14 cycles after is taken.
        wait_until(next_ok);
        do_read(21'h10, 4);
        c = cyc - 1;
        wait_until(c + 13);
        chk("busy_at_13", 64'(busy), 64'h1);
        cmd_en = 1'b1; cmd = 1'b1; addr = 21'h10; wr_data = 64'hDEADBEEFDEADBEEF;
        tick();
        chk("reject_cmd_error", 64'(cmd_error), 64'h1);
        do_read(21'h10, 4);

        // Reset during the second beat truncates the burst; memory survives.
        wait_until(next_ok);
        do_read(21'h10, 2);
        c = cyc - 1;
        wait_until(c + 8);
        rst = 1'b1;
        tick();
        chk("valid_after_rst", 64'(rd_data_valid), 64'h0);
        do_reset(1'b0);
        do_read(21'h10, 4);
        do_read(21'h1FFFFE, 4);

        repeat (20) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        chk("final_cmd_error", 64'(cmd_error), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
